muldiv_iter: RTL and testbench

//  Iterative multi-cycle multiply / multiply-accumulate / divide unit for the multi-cycle ARM core.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_iter_if.sv | 26 ++
 rtl/muldiv_iter.sv | 145 ++++++++++++++
 tb/tb_muldiv_iter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and magnitude/negate helpers for the iterative mul/div unit.
// Helpers work on a 64-bit carrier; callers zero-extend in and truncate out.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MLA  = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;

  localparam int DW = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  // Low N bits of the result are the N-bit two's-complement negation for any N <= DW.
  function automatic logic [DW-1:0] neg_w(input logic [DW-1:0] x);
    return ~x + DW'(1);
  endfunction

  function automatic logic [DW-1:0] abs_w(input logic [DW-1:0] x, input logic sgn);
    return sgn ? neg_w(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Controller <-> mul/div unit bundle: start/flush/operands in, busy/done/results out.
// master = controller side, slave = the muldiv_iter unit.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] rn;
  logic [WIDTH-1:0] rm;
  logic [WIDTH-1:0] acc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;

  modport master (
    output start, flush, op, rn, rm, acc,
    input  busy, done, result_lo, result_hi
  );

  modport slave (
    input  start, flush, op, rn, rm, acc,
    output busy, done, result_lo, result_hi
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative MUL/MLA/UDIV/SDIV, 1 bit per cycle; done at start+WIDTH+2 (divide-by-zero start+2).
// No backpressure: start ignored while busy; MULDIV_EARLY_EXIT_EN ends MUL/MLA once the multiplier is exhausted.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_iter_if.slave bus
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [W2-1:0]    a;      // MUL: product accumulator; DIV: {remainder, dividend/quotient}
  logic [W2-1:0]    b;      // MUL: shifted multiplicand
  logic [WIDTH-1:0] m;      // MUL: shifting multiplier; DIV: divisor magnitude
  logic             neg_q;
  logic             neg_r;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;

  logic [W2-1:0]    mul_sum;
  logic [W2-1:0]    div_next;
  logic [WIDTH:0]   rem_try;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic             last_iter;
  logic             mul_exit;
  logic             zero_skip;
  logic             is_div_in;
  logic [WIDTH-1:0] rn_mag;
  logic [WIDTH-1:0] rm_mag;

  always_comb begin
    mul_sum   = a + (m[0] ? b : '0);
    rem_try   = {a[W2-1:WIDTH], a[WIDTH-1]};
    rem_diff  = rem_try - {1'b0, m};
    q_bit     = ~rem_diff[WIDTH];
    div_next  = {(q_bit ? rem_diff[WIDTH-1:0] : rem_try[WIDTH-1:0]), a[WIDTH-2:0], q_bit};
    last_iter = (cnt == CW'(WIDTH - 1));
    rn_mag    = WIDTH'(abs_w(DW'(bus.rn), bus.rn[WIDTH-1]));
    rm_mag    = WIDTH'(abs_w(DW'(bus.rm), bus.rm[WIDTH-1]));
    is_div_in = bus.op[1];
`ifdef MULDIV_EARLY_EXIT_EN
    mul_exit  = ~op_q[1] & (m[WIDTH-1:1] == '0);
    zero_skip = (bus.rm == '0);
`else
    mul_exit  = 1'b0;
    zero_skip = is_div_in & (bus.rm == '0);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a      <= '0;
      b      <= '0;
      m      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
    end else if (state != IDLE && bus.flush) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q   <= bus.op;
            b      <= {{WIDTH{1'b0}}, bus.rn};
            m      <= bus.rm;
            cnt    <= '0;
            busy_q <= 1'b1;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            case (bus.op)
              OP_MUL:  a <= '0;
              OP_MLA:  a <= {{WIDTH{1'b0}}, bus.acc};
              OP_UDIV: a <= {{WIDTH{1'b0}}, bus.rn};
              default: begin
                a     <= {{WIDTH{1'b0}}, rn_mag};
                m     <= rm_mag;
                neg_q <= bus.rn[WIDTH-1] ^ bus.rm[WIDTH-1];
                neg_r <= bus.rn[WIDTH-1];
              end
            endcase
            if (zero_skip) begin
              state <= FIX;
              // Divide by zero reports quotient 0 and the raw dividend as remainder.
              if (is_div_in) begin
                a     <= {bus.rn, {WIDTH{1'b0}}};
                neg_q <= 1'b0;
                neg_r <= 1'b0;
              end
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (op_q[1]) begin
            a <= div_next;
          end else begin
            a <= mul_sum;
            b <= b << 1;
            m <= m >> 1;
          end
          if (last_iter || mul_exit) state <= FIX;
        end
        FIX: begin
          res_lo <= neg_q ? WIDTH'(neg_w(DW'(a[WIDTH-1:0])))  : a[WIDTH-1:0];
          res_hi <= neg_r ? WIDTH'(neg_w(DW'(a[W2-1:WIDTH]))) : a[W2-1:WIDTH];
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = res_lo;
  assign bus.result_hi = res_hi;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed + scoreboard bench for muldiv_iter at WIDTH=32 (latency model follows MULDIV_EARLY_EXIT_EN).
module tb_muldiv_iter;
  import muldiv_pkg::*;

  localparam int W     = 32;
  localparam int LIMIT = 60;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  muldiv_iter_if #(.WIDTH(W)) bus ();

  muldiv_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_lo  = '0;
  logic [31:0] last_hi  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] rm);
    if (op[1]) return (rm == 0) ? 2 : 34;
`ifdef MULDIV_EARLY_EXIT_EN
    if (rm == 0) return 2;
    for (int i = 31; i >= 0; i--) if (rm[i]) return 3 + i;
`endif
    return 34;
  endfunction

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] rn,
                                        input logic [31:0] rm, input logic [31:0] acc);
    int sa, sb;
    logic [31:0] q, r;
    model = '0;
    case (op)
      OP_MUL:  model = 64'(rn) * 64'(rm);
      OP_MLA:  model = 64'(rn) * 64'(rm) + 64'(acc);
      OP_UDIV: model = (rm == 0) ? {rn, 32'd0} : {rn % rm, rn / rm};
      default: begin
        sa = $signed(rn);
        sb = $signed(rm);
        if (rm == 0) model = {rn, 32'd0};
        else if (rn == 32'h8000_0000 && rm == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
        else begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
          model = {r, q};
        end
      end
    endcase
  endfunction

  // Launch one op, optionally poke a second start or a flush mid-flight, then score the result.
  task automatic run(input logic [1:0] op_i, input logic [31:0] rn_i, input logic [31:0] rm_i,
                     input logic [31:0] acc_i, input logic [31:0] lo_e, input logic [31:0] hi_e,
                     input string tag, input int intrude_at, input int flush_at,
                     input bit start_in_done);
    int   n;
    int   busy_n;
    int   lat_e;
    exp_t e;
    lat_e = exp_lat(op_i, rm_i);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.rn    = rn_i;
    bus.rm    = rm_i;
    bus.acc   = acc_i;
    if (flush_at < 0) exp_q.push_back('{lo: lo_e, hi: hi_e, lat: lat_e});
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.rn    = $urandom;
    bus.rm    = $urandom;
    bus.acc   = $urandom;
    n      = 1;
    busy_n = 0;
    while (n <= LIMIT) begin
      if (bus.busy) busy_n++;
      if (bus.done) break;
      if (flush_at >= 0 && n == flush_at + 1) check({tag, "_busy_after_flush"}, 64'(bus.busy), 64'(0));
      if (n == intrude_at) begin
        bus.start = 1'b1;
        bus.op    = OP_UDIV;
        bus.rn    = 32'd1000;
        bus.rm    = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      bus.flush = (n == flush_at);
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    if (flush_at >= 0) begin
      check({tag, "_no_done"}, 64'(n > LIMIT), 64'(1));
      check({tag, "_lo_held"}, 64'(bus.result_lo), 64'(last_lo));
      check({tag, "_hi_held"}, 64'(bus.result_hi), 64'(last_hi));
    end else begin
      check({tag, "_lat"}, 64'(n), 64'(lat_e));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_lo"}, 64'(bus.result_lo), 64'(e.lo));
        check({tag, "_hi"}, 64'(bus.result_hi), 64'(e.hi));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(e.lat));
        last_lo = e.lo;
        last_hi = e.hi;
      end
      if (start_in_done) begin
        bus.start = 1'b1;
        bus.op    = OP_UDIV;
        bus.rn    = 32'd9;
        bus.rm    = 32'd3;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (start_in_done) begin
        check({tag, "_done_start_ignored"}, 64'(bus.busy), 64'(0));
        check({tag, "_done_start_lo"}, 64'(bus.result_lo), 64'(last_lo));
      end
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [1:0]  rop;
    logic [31:0] rrn, rrm, racc;
    int          done_seen;

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = OP_MUL;
    bus.rn    = '0;
    bus.rm    = '0;
    bus.acc   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_lo", 64'(bus.result_lo), 64'(0));
    check("rst_hi", 64'(bus.result_hi), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(OP_MUL,  32'd7,         32'd6,         32'd0,  32'd42,        32'd0,        "mul_7x6",  -1, -1, 1'b0);
    run(OP_MLA,  32'hFFFF_FFFF, 32'd2,         32'd10, 32'd8,         32'd2,        "mla",      -1, -1, 1'b0);
    run(OP_UDIV, 32'd100,       32'd7,         32'd0,  32'd14,        32'd2,        "udiv",     -1, -1, 1'b0);
    run(OP_SDIV, 32'hFFFF_FF9C, 32'd7,         32'd0,  32'hFFFF_FFF2, 32'hFFFF_FFFE,"sdiv_neg", -1, -1, 1'b0);
    run(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,  32'h8000_0000, 32'd0,        "sdiv_ovf", -1, -1, 1'b0);
    run(OP_UDIV, 32'd55,        32'd0,         32'd0,  32'd0,         32'd55,       "udiv_by0", -1, -1, 1'b0);
    run(OP_SDIV, 32'hFFFF_FFFB, 32'd0,         32'd0,  32'd0,         32'hFFFF_FFFB,"sdiv_by0", -1, -1, 1'b1);
    run(OP_MUL,  32'd7,         32'd6,         32'd0,  32'd42,        32'd0,        "intrude",   3, -1, 1'b0);
    run(OP_MLA,  32'd5,         32'd5,         32'd1,  32'd0,         32'd0,        "flush",    -1, 10, 1'b0);
    run(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,  32'd1,         32'hFFFF_FFFE,"mul_max",  -1, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rop  = 2'(i % 4);
      rrn  = $urandom;
      rrm  = (i == 6) ? 32'd0 : ((i % 3 == 0) ? $urandom_range(1, 300) : $urandom);
      racc = $urandom;
      r    = model(rop, rrn, rrm, racc);
      run(rop, rrn, rrm, racc, r[31:0], r[63:32], "rand", -1, -1, 1'b0);
    end

    // Reset mid-operation: outputs clear at once and the op never completes.
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.rn    = 32'd7;
    bus.rm    = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_done", 64'(bus.done), 64'(0));
    check("midrst_lo", 64'(bus.result_lo), 64'(0));
    check("midrst_hi", 64'(bus.result_hi), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("midrst_no_done", 64'(done_seen), 64'(0));
    last_lo = '0;
    last_hi = '0;

    r = model(OP_SDIV, 32'd12345, 32'hFFFF_FFF9, 32'd0);
    run(OP_SDIV, 32'd12345, 32'hFFFF_FFF9, 32'd0, r[31:0], r[63:32], "post_rst", -1, -1, 1'b0);
    check("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
